md_unit: RTL
============

Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the E stage of the pipelined MIPS datapath.
- Operands are captured on `start`. `busy` is held high for a fixed, per-operation latency, then HI/LO commit.
- The hazard unit stalls later multiply/divide-class instructions (mfhi, mflo, mthi, mtlo, mult, div) while `start|busy` is high.
- Successor to the single-cycle E-stage ALU: operand width and latencies are parameters.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..255.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch the operation selected by `op`; sampled only when `busy`=0.
- op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- src_a  input  WIDTH  rs operand; dividend for div.
- src_b  input  WIDTH  rt operand; divisor for div.
- mthi  input  1  write `src_a` to HI.
- mtlo  input  1  write `src_a` to LO.
- busy  output  1  registered; operation in flight.
- hi  output  WIDTH  HI register; upper product half, or remainder.
- lo  output  WIDTH  LO register; lower product half, or quotient.

Behaviour:
- Reset: `busy`=0, `hi`=0, `lo`=0, internal counter=0, pending result discarded. Reset overrides every other input in the same cycle.
- States: IDLE, RUN.
- IDLE to RUN on an edge with `start`=1:
  - Load counter with MULT_CYCLES (op[1]=0) or DIV_CYCLES (op[1]=1).
  - Compute the result from the sampled `src_a`/`src_b` and hold it internally.
  - `busy` goes to 1 on that same edge.
- RUN: counter decrements every edge. On the edge where counter==1, commit the pending result to HI/LO, set `busy`=0, return to IDLE.
- Timing: `busy` is high for exactly N cycles after the start edge. New HI/LO values are visible in the first cycle `busy`=0. A `start` on that same cycle is accepted, giving back-to-back operation.
- HI/LO hold their old values throughout RUN. mfhi/mflo issued during RUN are stalled externally.
- mult/multu: full 2*WIDTH product, signed or unsigned; HI = upper WIDTH bits, LO = lower WIDTH bits.
- div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / -1: LO = MIN, HI = 0 (wrap, no trap).
- Divide by zero (`src_b`=0, div or divu): runs the full DIV_CYCLES with `busy` behaving normally. At commit, HI and LO are left unchanged.
- mthi/mtlo in IDLE without `start`: write `src_a` to HI/LO on the next edge. Both may be asserted together, writing both registers.
- Priority:
  - `start` beats mthi/mtlo in the same cycle; the moves are ignored.
  - mthi/mtlo and `start` are ignored while `busy`=1; they are neither queued nor aborted.
- No cancel input. An in-flight operation always completes unless `reset` is asserted.
- The counter width is 8 bits, sized for the legal latency range.

Test Plan:
- Reset, then mult with src_a=0xFFFFFFFF, src_b=0x00000002 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. Then div with src_a=0xFFFFFFF9 (-7), src_b=2 → busy high 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Edge cases:
  - Preload hi=0x11, lo=0x22 via mthi/mtlo, then div by zero → busy high 10 cycles; hi=0x11, lo=0x22 unchanged.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Assert start (multu 3×4) plus mtlo in the same cycle → mtlo ignored; lo=12, hi=0. During busy, pulse mthi and start (divu) → both ignored; hi/lo change only at the original commit.
- Back-to-back: assert a second start (divu 100/7) in the first cycle busy=0 after a mult → accepted; busy low for only that one cycle; final lo=14, hi=2.
- Assert reset in the 3rd busy cycle of a mult → next cycle busy=0, hi=0, lo=0. No commit ever occurs for the aborted operation.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the E stage.
// The result is computed when the operation is accepted and commits after a fixed latency.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES);

    state_t state, state_next;

    logic [7:0]       count;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_valid;

    logic accept;
    logic commit;
    logic write_hi;
    logic write_lo;

    logic is_div;
    logic is_signed;
    logic div_by_zero;

    logic [2*WIDTH-1:0] mul_a_ext;
    logic [2*WIDTH-1:0] mul_b_ext;
    logic [2*WIDTH-1:0] product;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] b_safe;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    assign is_div      = op[1];
    assign is_signed   = ~op[0];
    assign div_by_zero = (src_b == '0);
    assign busy        = (state == RUN);

    // Product over sign- or zero-extended operands; the low 2*WIDTH bits are exact either way.
    always_comb begin
        mul_a_ext = is_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
        mul_b_ext = is_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
        product   = mul_a_ext * mul_b_ext;
    end

    // Signed divide on magnitudes: MIN/-1 wraps to MIN with remainder 0 instead of overflowing.
    always_comb begin
        a_neg  = is_signed & src_a[WIDTH-1];
        b_neg  = is_signed & src_b[WIDTH-1];
        a_mag  = a_neg ? -src_a : src_a;
        b_mag  = b_neg ? -src_b : src_b;
        b_safe = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        uq     = a_mag / b_safe;
        ur     = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -uq : uq;
        rem    = a_neg ? -ur : ur;
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        commit     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    write_hi = mthi;
                    write_lo = mtlo;
                end
            end
            RUN: begin
                if (count == 8'd1) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 8'd0;
            hi         <= '0;
            lo         <= '0;
            // NOTE: the pending result is cleared as well, so an aborted operation can never commit.
            pend_hi    <= '0;
            pend_lo    <= '0;
            pend_valid <= 1'b0;
        end else if (accept) begin
            count      <= is_div ? DIV_LOAD : MULT_LOAD;
            pend_hi    <= is_div ? rem  : product[2*WIDTH-1:WIDTH];
            pend_lo    <= is_div ? quot : product[WIDTH-1:0];
            pend_valid <= ~(is_div & div_by_zero);
        end else if (state == RUN) begin
            count <= count - 8'd1;
            if (commit && pend_valid) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else begin
            if (write_hi) hi <= src_a;
            if (write_lo) lo <= src_a;
        end
    end

endmodule
